serial_link_cfg_apb_regs: RTL and testbench
===========================================

Name: serial_link_cfg_apb_regs

Overview:
- APB completer (responder) holding the serial link control/status registers; it is the target end of the configuration accesses a bring-up sequence issues.
- Drives the link clock-enable, link reset and AXI isolation requests.
- Reports isolation status back through a read-only register.
- Sits between the system APB configuration bus and the serial link core / AXI isolation units, in the register clock domain.

Parameters:
AddrWidth, 32, APB address width (>= 4).
DataWidth, 32, APB data width (fixed 32; other values are illegal, elaboration-time assertion).
WaitStates, 1, number of extra access-phase cycles before pready (0..15).
MaxClkDiv, 1024, largest legal CLK_DIV value.
ClkDivRst, 8, reset value of CLK_DIV (must satisfy 1 <= ClkDivRst <= MaxClkDiv).
IsoTimeout, 256, timeout in cycles for the optional isolation watchdog.

Ports:
clk_i  in  1  register clock
rst_ni  in  1  asynchronous active-low reset
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  APB write
paddr_i  in  AddrWidth  APB address
pwdata_i  in  32  APB write data
pstrb_i  in  4  APB byte strobes
prdata_o  out  32  APB read data
pready_o  out  1  APB ready
pslverr_o  out  1  APB error
clk_ena_o  out  1  link clock enable (CTRL[0])
link_rst_no  out  1  link reset, active low (CTRL[1])
isolate_o  out  2  isolation request [0]=axi_in, [1]=axi_out (CTRL[9:8])
isolated_i  in  2  isolation acknowledge from isolation units
clk_div_o  out  $clog2(MaxClkDiv+1)  PHY clock divider

Behaviour:
- Reset (async, rst_ni low):
  - prdata_o=0, pready_o=0, pslverr_o=0.
  - CTRL=0x300: clk_ena_o=0, link_rst_no=0, isolate_o=2'b11.
  - CLK_DIV=ClkDivRst; isolated status register = 2'b00; wait counter = 0.
  - Deassertion takes effect on the next clk_i edge.
- Register map, word-decoded on paddr_i[3:2]; paddr_i[1:0] ignored; upper address bits ignored:
  - 0x0 CTRL, RW: bits [0], [1], [9:8]; other bits read 0 and ignore writes.
  - 0x4 ISOLATED, RO: [1:0] = registered copy of isolated_i (1-cycle delay); other bits read 0.
  - 0x8 CLK_DIV, RW: low bits hold the divider; upper bits read 0.
  - 0xC: unmapped.
- FSM IDLE -> ACCESS -> RESP:
  - IDLE: psel_i & penable_i moves to ACCESS and clears the wait counter.
  - ACCESS: counter increments each cycle. When the counter equals WaitStates, the FSM registers response data and goes to RESP.
  - RESP: pready_o=1 for exactly one cycle, with prdata_o and pslverr_o valid; then back to IDLE.
  - Latency: pready_o is high WaitStates+1 cycles after the first access-phase cycle. With WaitStates=0, pready_o is high in the 2nd access cycle.
- Write commit:
  - Writes commit only in the cycle the FSM enters RESP.
  - pstrb_i applies per byte: byte0 controls CTRL[1:0], byte1 controls CTRL[9:8].
  - CLK_DIV updates only if all strobe bytes covering the field are set.
- Errors (pslverr_o=1, no state change, prdata_o=0):
  - Unmapped address.
  - Write to ISOLATED.
  - CLK_DIV write of 0 or of a value > MaxClkDiv.
- Read data returns register contents as of the cycle before commit. A read and write of the same register never coincide, because APB is single-outstanding.
- psel_i deasserted while in ACCESS (master abort, protocol violation):
  - FSM returns to IDLE with no commit and no pready_o.
- prdata_o holds its last value outside RESP; it is cleared to 0 on error.
- isolated_i is used as-is (same clock domain); only the status register adds 1-cycle latency.
- Reset asserted mid-access aborts the transfer; no partial commit.

Optional Feature:
- Macro SERIAL_LINK_CFG_ISO_WATCHDOG_EN.
- When defined:
  - A per-bit counter runs while isolate_o[k] != isolated_i[k].
  - The counter saturates at IsoTimeout and sets the sticky ISOLATED[8+k] error bit.
  - The error bit clears when a CTRL write changes isolate_o[k], or on reset.
- When undefined: no counters exist and ISOLATED[9:8] reads 0.

Test Plan:
- Post-reset read CTRL -> prdata 0x300, pslverr 0. Read CLK_DIV -> 8. clk_ena_o=0, link_rst_no=0, isolate_o=2'b11.
- Write CTRL 0x303, then 0x003 with isolated_i following isolate_o one cycle later -> clk_ena_o=1, link_rst_no=1, isolate_o=0. Read ISOLATED -> 0x0.
- WaitStates=3: measure psel&penable to pready -> pready is high exactly in the 5th access cycle, for one cycle. Repeat with WaitStates=0 -> 2nd access cycle.
- Error cases, each leaving registers unchanged and returning pslverr 1, prdata 0:
  - Write 0x5 to 0x4.
  - Read 0xC.
  - Write 0 to CLK_DIV.
  - Write 1025 to CLK_DIV.
- Write CTRL 0x0000_0101 with pstrb 4'b0010 -> only byte1 updates: CTRL becomes 0x103 from 0x003.
- Reset asserted during ACCESS of a write to CTRL -> CTRL=0x300 after reset, no pready seen. With SERIAL_LINK_CFG_ISO_WATCHDOG_EN, hold isolated_i[0]=1 while isolate_o[0]=0 for 256 cycles -> ISOLATED[8]=1.

Source files
------------

// File: rtl/serial_link_cfg_apb_regs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : serial_link_cfg_apb_regs
// Purpose  : APB completer for serial link CTRL / ISOLATED / CLK_DIV registers.
//            Optional isolation watchdog: SERIAL_LINK_CFG_ISO_WATCHDOG_EN
// Revision : 1.0
// ---------------------------------------------------------------------------
module serial_link_cfg_apb_regs #(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned WaitStates = 1,
  parameter int unsigned MaxClkDiv  = 1024,
  parameter int unsigned ClkDivRst  = 8,
  parameter int unsigned IsoTimeout = 256,
  localparam int unsigned ClkDivW   = $clog2(MaxClkDiv + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [AddrWidth-1:0] paddr_i,
  input  logic [31:0]          pwdata_i,
  input  logic [3:0]           pstrb_i,
  output logic [31:0]          prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  output logic                 clk_ena_o,
  output logic                 link_rst_no,
  output logic [1:0]           isolate_o,
  input  logic [1:0]           isolated_i,
  output logic [ClkDivW-1:0]   clk_div_o
);

  localparam int unsigned c_DivTopByte = (ClkDivW - 1) / 8;

  if (DataWidth != 32) begin : g_chk_dw
    $error("DataWidth must be 32");
  end
  if (AddrWidth < 4) begin : g_chk_aw
    $error("AddrWidth must be at least 4");
  end
  if (WaitStates > 15) begin : g_chk_ws
    $error("WaitStates must be in 0..15");
  end
  if ((ClkDivRst < 1) || (ClkDivRst > MaxClkDiv)) begin : g_chk_div
    $error("ClkDivRst must be in 1..MaxClkDiv");
  end
  if (IsoTimeout < 1) begin : g_chk_iso
    $error("IsoTimeout must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [4:0]           w_cnt_inc;
  logic                 w_start_resp;

  logic [1:0]           ctrl_lo_q;
  logic [1:0]           iso_req_q;
  logic [ClkDivW-1:0]   clk_div_q;
  logic [1:0]           iso_q;
  logic [31:0]          prdata_q;
  logic                 pslverr_q;

  logic [31:0]          w_rdata;
  logic                 w_err;
  logic                 w_ctrl_we;
  logic                 w_div_we;
  logic [1:0]           w_iso_chg;
  logic [1:0]           w_iso_err;

  assign w_cnt_inc = {1'b0, cnt_q} + 5'd1;

  // The cycle in which IDLE sees psel&penable is the first access cycle, so
  // ACCESS lasts WaitStates cycles and zero wait states skips it entirely.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    w_start_resp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (psel_i && penable_i) begin
          cnt_d = '0;
          if (WaitStates == 0) begin
            state_d      = ST_RESP;
            w_start_resp = 1'b1;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = w_cnt_inc[3:0];
        if (!psel_i) begin
          state_d = ST_IDLE;
        end else if (w_cnt_inc == 5'(WaitStates)) begin
          state_d      = ST_RESP;
          w_start_resp = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    unique case (paddr_i[3:2])
      2'd0: w_rdata = {22'b0, iso_req_q, 6'b0, ctrl_lo_q};
      2'd1: begin
        w_rdata = {22'b0, w_iso_err, 6'b0, iso_q};
        w_err   = pwrite_i;
      end
      2'd2: begin
        w_rdata = 32'(clk_div_q);
        w_err   = pwrite_i && ((pwdata_i == '0) || (pwdata_i > 32'(MaxClkDiv)));
      end
      default: w_err = 1'b1;
    endcase
  end

  assign w_ctrl_we = w_start_resp && pwrite_i && !w_err && (paddr_i[3:2] == 2'd0);
  assign w_div_we  = w_start_resp && pwrite_i && !w_err && (paddr_i[3:2] == 2'd2)
                   && (&pstrb_i[c_DivTopByte:0]);

  for (genvar k = 0; k < 2; k++) begin : g_iso_chg
    assign w_iso_chg[k] = w_ctrl_we && pstrb_i[1] && (pwdata_i[8+k] != iso_req_q[k]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ctrl_lo_q <= 2'b00;
      iso_req_q <= 2'b11;
      clk_div_q <= ClkDivW'(ClkDivRst);
      iso_q     <= 2'b00;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      iso_q     <= isolated_i;
      pslverr_q <= w_start_resp && w_err;
      if (w_start_resp) begin
        prdata_q <= w_err ? 32'b0 : w_rdata;
      end
      if (w_ctrl_we) begin
        if (pstrb_i[0]) ctrl_lo_q <= pwdata_i[1:0];
        if (pstrb_i[1]) iso_req_q <= pwdata_i[9:8];
      end
      if (w_div_we) begin
        clk_div_q <= pwdata_i[ClkDivW-1:0];
      end
    end
  end

`ifdef SERIAL_LINK_CFG_ISO_WATCHDOG_EN
  localparam int unsigned c_WdW = $clog2(IsoTimeout + 1);

  for (genvar k = 0; k < 2; k++) begin : g_wdog
    logic [c_WdW-1:0] wd_q;
    logic             err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wd_q  <= '0;
        err_q <= 1'b0;
      end else if (w_iso_chg[k]) begin
        wd_q  <= '0;
        err_q <= 1'b0;
      end else if (iso_req_q[k] != isolated_i[k]) begin
        if (wd_q != c_WdW'(IsoTimeout)) wd_q <= wd_q + 1'b1;
        if (wd_q >= c_WdW'(IsoTimeout - 1)) err_q <= 1'b1;
      end else begin
        wd_q <= '0;
      end
    end

    assign w_iso_err[k] = err_q;
  end
`else
  assign w_iso_err = 2'b00;
`endif

  logic unused_ok;
  assign unused_ok = ^{paddr_i, pstrb_i, w_iso_chg};

  assign prdata_o    = prdata_q;
  assign pready_o    = (state_q == ST_RESP);
  assign pslverr_o   = pslverr_q;
  assign clk_ena_o   = ctrl_lo_q[0];
  assign link_rst_no = ctrl_lo_q[1];
  assign isolate_o   = iso_req_q;
  assign clk_div_o   = clk_div_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_link_cfg_apb_regs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_serial_link_cfg_apb_regs
// Purpose  : Directed self-checking bench for serial_link_cfg_apb_regs.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_serial_link_cfg_apb_regs;

  localparam int unsigned WS = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr, clk_ena, link_rst_n;
  logic [1:0]  isolate, isolated;
  logic [10:0] clk_div;

  logic        psel0, penable0, pwrite0;
  logic [31:0] paddr0, pwdata0, prdata0;
  logic [3:0]  pstrb0;
  logic        pready0, pslverr0, clk_ena0, link_rst_n0;
  logic [1:0]  isolate0, isolated0;
  logic [10:0] clk_div0;

  int tests = 0;
  int fails = 0;

  serial_link_cfg_apb_regs #(.WaitStates(WS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .clk_ena_o(clk_ena), .link_rst_no(link_rst_n), .isolate_o(isolate),
    .isolated_i(isolated), .clk_div_o(clk_div)
  );

  serial_link_cfg_apb_regs #(.WaitStates(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel0), .penable_i(penable0),
    .pwrite_i(pwrite0), .paddr_i(paddr0), .pwdata_i(pwdata0), .pstrb_i(pstrb0),
    .prdata_o(prdata0), .pready_o(pready0), .pslverr_o(pslverr0),
    .clk_ena_o(clk_ena0), .link_rst_no(link_rst_n0), .isolate_o(isolate0),
    .isolated_i(isolated0), .clk_div_o(clk_div0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One APB transfer with setup phase; checks latency and single-cycle pready.
  task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wd, input logic [3:0] strb,
                      output logic [31:0] rd, output logic err);
    int cyc;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 1;
    while (pready !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    rd  = prdata;
    err = pslverr;
    chk({tag, "/latency"}, 32'(cyc), 32'(WS + 2));
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk({tag, "/pready_1cyc"}, {31'b0, pready}, 32'h0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr,
                        input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    xfer(tag, addr, 1'b0, 32'h0, 4'h0, rd, err);
    chk({tag, "/prdata"}, rd, exp_rd);
    chk({tag, "/pslverr"}, {31'b0, err}, {31'b0, exp_err});
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    xfer(tag, addr, 1'b1, wd, strb, rd, err);
    chk({tag, "/pslverr"}, {31'b0, err}, {31'b0, exp_err});
    if (exp_err) chk({tag, "/prdata_zero"}, rd, 32'h0);
  endtask

  initial begin
    logic seen;
    int   cyc;
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0;
    psel0 = 0; penable0 = 0; pwrite0 = 0; paddr0 = 0; pwdata0 = 0; pstrb0 = 0;
    isolated = 2'b11; isolated0 = 2'b11;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst/pready", {31'b0, pready}, 32'h0);
    chk("rst/pslverr", {31'b0, pslverr}, 32'h0);
    chk("rst/prdata", prdata, 32'h0);
    chk("rst/ctrl_outs", {29'b0, clk_ena, link_rst_n, 1'b0}, 32'h0);
    chk("rst/isolate", {30'b0, isolate}, 32'h3);
    chk("rst/clk_div", {21'b0, clk_div}, 32'd8);
    rst_n = 1'b1;

    rd_chk("rd_ctrl_rst", 32'h0, 32'h300, 1'b0);
    rd_chk("rd_div_rst", 32'h8, 32'd8, 1'b0);

    // Link bring-up
    wr_chk("wr_ctrl_303", 32'h0, 32'h303, 4'hF, 1'b0);
    chk("bringup/clk_ena", {31'b0, clk_ena}, 32'h1);
    chk("bringup/link_rst_n", {31'b0, link_rst_n}, 32'h1);
    chk("bringup/isolate_11", {30'b0, isolate}, 32'h3);
    rd_chk("rd_iso_11", 32'h4, 32'h3, 1'b0);
    wr_chk("wr_ctrl_003", 32'h0, 32'h003, 4'hF, 1'b0);
    chk("bringup/isolate_00", {30'b0, isolate}, 32'h0);
    @(posedge clk); #1;
    isolated = 2'b00;
    rd_chk("rd_iso_00", 32'h4, 32'h0, 1'b0);

    // Error responses leave state untouched
    wr_chk("err_wr_iso", 32'h4, 32'h5, 4'hF, 1'b1);
    rd_chk("rd_ctrl_after_err", 32'h0, 32'h003, 1'b0);
    rd_chk("err_rd_unmapped", 32'hC, 32'h0, 1'b1);
    wr_chk("err_div_0", 32'h8, 32'h0, 4'hF, 1'b1);
    wr_chk("err_div_1025", 32'h8, 32'd1025, 4'hF, 1'b1);
    chk("div_after_err", {21'b0, clk_div}, 32'd8);

    // CLK_DIV boundary and partial strobe
    wr_chk("wr_div_1024", 32'h8, 32'd1024, 4'hF, 1'b0);
    chk("div_1024", {21'b0, clk_div}, 32'd1024);
    wr_chk("wr_div_partial", 32'h8, 32'd5, 4'b0001, 1'b0);
    rd_chk("rd_div_1024", 32'h8, 32'h400, 1'b0);

    // Byte strobes on CTRL
    wr_chk("wr_ctrl_strb1", 32'h0, 32'h0000_0101, 4'b0010, 1'b0);
    rd_chk("rd_ctrl_103", 32'h0, 32'h103, 1'b0);
    chk("strb/isolate_01", {30'b0, isolate}, 32'h1);

    // Address aliasing: upper and low two bits ignored
    rd_chk("rd_alias_hi", 32'h10, 32'h103, 1'b0);
    rd_chk("rd_alias_lo", 32'hB, 32'h400, 1'b0);

    // Master abort during ACCESS
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h0; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    seen = pready;
    psel = 1'b0; penable = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | pready;
    end
    chk("abort/no_pready", {31'b0, seen}, 32'h0);
    rd_chk("abort/ctrl_kept", 32'h0, 32'h103, 1'b0);

    // Reset during ACCESS of a CTRL write
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h003; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    seen = pready;
    @(posedge clk); #1;
    seen = seen | pready;
    rst_n = 1'b0;
    #1;
    seen = seen | pready;
    chk("midrst/no_pready", {31'b0, seen}, 32'h0);
    chk("midrst/isolate", {30'b0, isolate}, 32'h3);
    psel = 1'b0; penable = 1'b0;
    isolated = 2'b11;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst/clk_ena", {31'b0, clk_ena}, 32'h0);
    rd_chk("midrst/ctrl_300", 32'h0, 32'h300, 1'b0);

`ifdef SERIAL_LINK_CFG_ISO_WATCHDOG_EN
    wr_chk("wd/wr_ctrl_003", 32'h0, 32'h003, 4'hF, 1'b0);
    isolated = 2'b01;
    repeat (260) @(posedge clk);
    #1;
    rd_chk("wd/iso_err", 32'h4, 32'h101, 1'b0);
    wr_chk("wd/wr_ctrl_103", 32'h0, 32'h103, 4'hF, 1'b0);
    rd_chk("wd/iso_err_clr", 32'h4, 32'h001, 1'b0);
`endif

    // Zero-wait-state instance: pready in the 2nd access cycle
    @(posedge clk); #1;
    psel0 = 1'b1; penable0 = 1'b0; paddr0 = 32'h0;
    @(posedge clk); #1;
    penable0 = 1'b1;
    cyc = 1;
    while (pready0 !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ws0/latency", 32'(cyc), 32'd2);
    chk("ws0/prdata", prdata0, 32'h300);
    psel0 = 1'b0; penable0 = 1'b0;
    @(posedge clk); #1;
    chk("ws0/pready_1cyc", {31'b0, pready0}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
